// File: rtl/hicore_lsu_pkg.sv
// Shared definitions for the load/store unit: op encoding, i_info layout, FSM states.
package hicore_lsu_pkg;
  localparam int XLEN      = 32;
  localparam int INFO_W    = 73;
  localparam int ADDR_LSB  = 0;
  localparam int WDATA_LSB = 32;
  localparam int OP_LSB    = 64;
  localparam int RD_LSB    = 68;

  localparam int OP_ST  = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;
endpackage

// File: rtl/hicore_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface hicore_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/hicore_lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, misalign detect, load extend.
module hicore_lsu_align
  import hicore_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic        misalign,
  output logic [31:0] ld_data
);
  logic [1:0]  sz;
  logic [15:0] lane;

  assign sz   = op[1:0];
  assign lane = 16'(rdata >> {addr, 3'b000});
  // Reserved size 11 behaves as a word everywhere.
  assign misalign = ((sz == SZ_H) && addr[0]) || (sz[1] && (addr != 2'b00));

  always_comb begin
    st_data = wdata;
    st_strb = 4'b1111;
    ld_data = rdata;
    case (sz)
      SZ_B: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr;
        ld_data = op[OP_UNS] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        st_data = {2{wdata[15:0]}};
        st_strb = 4'b0011 << addr;
        ld_data = op[OP_UNS] ? {16'h0, lane} : {{16{lane[15]}}, lane};
      end
      default: ;
    endcase
    if (!op[OP_ST]) st_strb = 4'b0000;
  end
endmodule

// File: rtl/hicore_lsu.sv
// Load/store unit: one data-memory access in flight, with cancel, flush and misalign trap.
module hicore_lsu
  import hicore_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_cancel,
  input  logic [INFO_W-1:0] i_info,
  input  logic              flush,
  hicore_lsu_if.master      mem,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_err,
  output logic [31:0]       wb_err_addr
);
  state_t      state;
  logic        killed;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  op_q, wstrb_q;
  logic [4:0]  rd_q;

  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_strb;
  logic        misalign;

  assign in_addr  = i_info[ADDR_LSB +: 32];
  assign in_wdata = i_info[WDATA_LSB +: 32];
  assign in_op    = i_info[OP_LSB +: 4];
  assign in_rd    = i_info[RD_LSB +: 5];

  // One aligner serves both phases: incoming op while idle, held op afterwards.
  hicore_lsu_align u_align (
    .op       (state == IDLE ? in_op : op_q),
    .addr     (state == IDLE ? in_addr[1:0] : addr_q[1:0]),
    .wdata    (in_wdata),
    .rdata    (mem.mem_rsp_rdata),
    .st_data  (st_data),
    .st_strb  (st_strb),
    .misalign (misalign),
    .ld_data  (ld_data)
  );

  assign i_ready           = (state == IDLE);
  assign wb_valid          = (state == WB);
  assign wb_rd             = rd_q;
  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_req_wen   = op_q[OP_ST];
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wstrb = wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      killed      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= '0;
      wstrb_q     <= '0;
      rd_q        <= '0;
      wb_we       <= 1'b0;
      wb_data     <= '0;
      wb_err      <= 1'b0;
      wb_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (i_valid && !i_cancel && !flush) begin
            addr_q      <= in_addr;
            op_q        <= in_op;
            rd_q        <= in_rd;
            wdata_q     <= st_data;
            wstrb_q     <= st_strb;
            wb_we       <= !in_op[OP_ST] && (in_rd != 5'd0) && !misalign;
            wb_data     <= '0;
            wb_err      <= misalign;
            wb_err_addr <= misalign ? in_addr : 32'h0;
            state       <= misalign ? WB : REQ;
          end
        end
        REQ: begin
          // A posted request is never withdrawn; flush only suppresses writeback.
          if (flush) killed <= 1'b1;
          if (mem.mem_req_ready) state <= RESP;
        end
        RESP: begin
          if (flush) killed <= 1'b1;
          if (mem.mem_rsp_valid) begin
            if (!op_q[OP_ST]) wb_data <= ld_data;
            state <= (killed || flush) ? IDLE : WB;
          end
        end
        WB: if (wb_ready || flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hicore_lsu.sv
// Directed, table-driven bench for hicore_lsu with a cycle-stepped memory/writeback model.
module tb_hicore_lsu;
  import hicore_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_cancel = 1'b0, flush = 1'b0, wb_ready = 1'b0;
  logic [INFO_W-1:0] i_info = '0;
  logic i_ready, wb_valid, wb_we, wb_err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data, wb_err_addr;

  hicore_lsu_if mem_if ();

  hicore_lsu dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_cancel(i_cancel),
    .i_info(i_info), .flush(flush), .mem(mem_if.master), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .wb_err_addr(wb_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] wdata, addr, rdata;
    int          req_wait, wb_wait;
    bit          exp_req;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          exp_we;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[13];

  bit          r_saw_req, r_req_stable, r_wb_seen, r_wb_stable, r_timeout;
  int          r_nreq, r_nwb, r_wb_lat;
  logic [31:0] r_addr, r_wdata, r_data, r_eaddr;
  logic [3:0]  r_wstrb;
  logic        r_wen, r_we, r_err;
  logic [4:0]  r_rd;

  task automatic run_op(input logic [INFO_W-1:0] info, input logic [31:0] rdata,
                        input int req_wait, input int wb_wait);
    int lat, rs, ws;
    bit hs_prev, done;
    r_saw_req = 0; r_req_stable = 1; r_wb_seen = 0; r_wb_stable = 1; r_timeout = 0;
    r_nreq = 0; r_nwb = 0; r_wb_lat = -1;
    i_valid = 1; i_cancel = 0; i_info = info;
    tick();
    i_valid = 0;
    lat = 1; rs = 0; ws = 0; hs_prev = 0; done = 0;
    while (!done && lat < 60) begin
      mem_if.mem_rsp_valid = hs_prev;
      mem_if.mem_rsp_rdata = hs_prev ? rdata : 32'h0;
      hs_prev = 0;
      mem_if.mem_req_ready = 0;
      if (mem_if.mem_req_valid) begin
        if (!r_saw_req) begin
          r_saw_req = 1;
          r_addr = mem_if.mem_req_addr; r_wdata = mem_if.mem_req_wdata;
          r_wstrb = mem_if.mem_req_wstrb; r_wen = mem_if.mem_req_wen;
        end else if (r_addr !== mem_if.mem_req_addr || r_wdata !== mem_if.mem_req_wdata ||
                     r_wstrb !== mem_if.mem_req_wstrb || r_wen !== mem_if.mem_req_wen)
          r_req_stable = 0;
        if (rs < req_wait) rs++;
        else begin
          mem_if.mem_req_ready = 1; hs_prev = 1; r_nreq++;
        end
      end
      wb_ready = 0;
      if (wb_valid) begin
        if (!r_wb_seen) begin
          r_wb_seen = 1; r_wb_lat = lat;
          r_we = wb_we; r_rd = wb_rd; r_data = wb_data; r_err = wb_err; r_eaddr = wb_err_addr;
        end else if (r_we !== wb_we || r_rd !== wb_rd || r_data !== wb_data ||
                     r_err !== wb_err || r_eaddr !== wb_err_addr)
          r_wb_stable = 0;
        if (ws < wb_wait) ws++;
        else begin
          wb_ready = 1; r_nwb++; done = 1;
        end
      end
      tick();
      lat++;
    end
    mem_if.mem_req_ready = 0; mem_if.mem_rsp_valid = 0; wb_ready = 0;
    if (!done) r_timeout = 1;
  endtask

  initial begin
    mem_if.mem_req_ready = 0; mem_if.mem_rsp_valid = 0; mem_if.mem_rsp_rdata = 0;
    //           rd     op       wdata         addr          rdata         rw ww req exp_addr     exp_wdata     strb     we exp_data      err
    vecs[0]  = '{5'd5,  4'b0010, 32'h0,        32'h0000_1000, 32'hDEADBEEF, 0, 0, 1, 32'h1000, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 0};
    vecs[1]  = '{5'd7,  4'b0000, 32'h0,        32'h0000_2003, 32'h80FFFF7F, 0, 0, 1, 32'h2000, 32'h0,        4'b0000, 1, 32'hFFFFFF80, 0};
    vecs[2]  = '{5'd7,  4'b0100, 32'h0,        32'h0000_2003, 32'h80FFFF7F, 0, 0, 1, 32'h2000, 32'h0,        4'b0000, 1, 32'h00000080, 0};
    vecs[3]  = '{5'd3,  4'b1001, 32'h1234ABCD, 32'h0000_3002, 32'h0,        0, 0, 1, 32'h3000, 32'hABCDABCD, 4'b1100, 0, 32'h0,        0};
    vecs[4]  = '{5'd2,  4'b0010, 32'h0,        32'h0000_4001, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[5]  = '{5'd4,  4'b0001, 32'h0,        32'h0000_5002, 32'h80011234, 0, 0, 1, 32'h5000, 32'h0,        4'b0000, 1, 32'hFFFF8001, 0};
    vecs[6]  = '{5'd6,  4'b1000, 32'h000000A5, 32'h0000_6001, 32'h0,        0, 0, 1, 32'h6000, 32'hA5A5A5A5, 4'b0010, 0, 32'h0,        0};
    vecs[7]  = '{5'd1,  4'b1010, 32'h11223344, 32'h0000_7000, 32'h0,        0, 0, 1, 32'h7000, 32'h11223344, 4'b1111, 0, 32'h0,        0};
    vecs[8]  = '{5'd0,  4'b0010, 32'h0,        32'h0000_7004, 32'hCAFEF00D, 0, 0, 1, 32'h7004, 32'h0,        4'b0000, 0, 32'hCAFEF00D, 0};
    vecs[9]  = '{5'd9,  4'b0101, 32'h0,        32'h0000_8002, 32'hFEDC0000, 5, 3, 1, 32'h8000, 32'h0,        4'b0000, 1, 32'h0000FEDC, 0};
    vecs[10] = '{5'd10, 4'b0011, 32'h0,        32'h0000_9000, 32'h01020304, 0, 1, 1, 32'h9000, 32'h0,        4'b0000, 1, 32'h01020304, 0};
    vecs[11] = '{5'd11, 4'b0001, 32'h0,        32'h0000_A001, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[12] = '{5'd12, 4'b0000, 32'h0,        32'h0000_B001, 32'h00009A00, 0, 0, 1, 32'hB000, 32'h0,        4'b0000, 1, 32'hFFFFFF9A, 0};

    #1;
    chk("rst_i_ready", i_ready, 1);
    chk("rst_req_valid", mem_if.mem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wstrb", mem_if.mem_req_wstrb, 0);
    chk("rst_addr", mem_if.mem_req_addr, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_wb_data", wb_data, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    for (int i = 0; i < 13; i++) begin
      vec_t v;
      v = vecs[i];
      run_op({v.rd, v.op, v.wdata, v.addr}, v.rdata, v.req_wait, v.wb_wait);
      chk($sformatf("v%0d_timeout", i), r_timeout, 0);
      chk($sformatf("v%0d_saw_req", i), r_saw_req, v.exp_req);
      chk($sformatf("v%0d_nreq", i), r_nreq, v.exp_req ? 1 : 0);
      if (v.exp_req) begin
        chk($sformatf("v%0d_addr", i), r_addr, v.exp_addr);
        chk($sformatf("v%0d_wstrb", i), r_wstrb, v.exp_wstrb);
        chk($sformatf("v%0d_wen", i), r_wen, v.op[3]);
        chk($sformatf("v%0d_req_stable", i), r_req_stable, 1);
        if (v.op[3]) chk($sformatf("v%0d_wdata", i), r_wdata, v.exp_wdata);
      end
      chk($sformatf("v%0d_nwb", i), r_nwb, 1);
      chk($sformatf("v%0d_wb_lat", i), r_wb_lat, v.exp_err ? 1 : 3 + v.req_wait);
      chk($sformatf("v%0d_we", i), r_we, v.exp_we);
      chk($sformatf("v%0d_rd", i), r_rd, v.rd);
      chk($sformatf("v%0d_err", i), r_err, v.exp_err);
      if (v.exp_err) chk($sformatf("v%0d_err_addr", i), r_eaddr, v.addr);
      if (!v.op[3] && !v.exp_err) chk($sformatf("v%0d_data", i), r_data, v.exp_data);
      chk($sformatf("v%0d_wb_stable", i), r_wb_stable, 1);
      chk($sformatf("v%0d_ready_after", i), i_ready, 1);
      chk($sformatf("v%0d_wb_drop", i), wb_valid, 0);
    end

    // Cancelled entry: consumed in one cycle, no bus or writeback.
    i_valid = 1; i_cancel = 1; i_info = {5'd5, 4'b0010, 32'h0, 32'h1000};
    chk("cancel_ready", i_ready, 1);
    tick();
    i_valid = 0; i_cancel = 0;
    chk("cancel_no_req", mem_if.mem_req_valid, 0);
    chk("cancel_no_wb", wb_valid, 0);
    chk("cancel_idle", i_ready, 1);

    // Flush coincident with acceptance behaves as a cancel.
    i_valid = 1; flush = 1;
    tick();
    i_valid = 0; flush = 0;
    chk("flush_acc_no_req", mem_if.mem_req_valid, 0);
    chk("flush_acc_idle", i_ready, 1);

    // Stray response while idle is ignored.
    mem_if.mem_rsp_valid = 1; mem_if.mem_rsp_rdata = 32'h55;
    tick();
    mem_if.mem_rsp_valid = 0;
    chk("stray_rsp_no_wb", wb_valid, 0);
    chk("stray_rsp_idle", i_ready, 1);

    // Flush while in RESP: response consumed, no writeback.
    i_valid = 1; i_info = {5'd5, 4'b0010, 32'h0, 32'h1000};
    tick();
    i_valid = 0;
    chk("fresp_req", mem_if.mem_req_valid, 1);
    mem_if.mem_req_ready = 1;
    tick();
    mem_if.mem_req_ready = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("fresp_busy", i_ready, 0);
    mem_if.mem_rsp_valid = 1; mem_if.mem_rsp_rdata = 32'h12345678;
    tick();
    mem_if.mem_rsp_valid = 0;
    chk("fresp_ready", i_ready, 1);
    chk("fresp_no_wb", wb_valid, 0);
    tick();
    chk("fresp_no_wb2", wb_valid, 0);

    // Flush while in REQ: request held until accepted, then response dropped.
    i_valid = 1; i_info = {5'd6, 4'b0010, 32'h0, 32'h2000};
    tick();
    i_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("freq_held", mem_if.mem_req_valid, 1);
    chk("freq_addr", mem_if.mem_req_addr, 32'h2000);
    mem_if.mem_req_ready = 1;
    tick();
    mem_if.mem_req_ready = 0;
    chk("freq_req_gone", mem_if.mem_req_valid, 0);
    mem_if.mem_rsp_valid = 1;
    tick();
    mem_if.mem_rsp_valid = 0;
    chk("freq_no_wb", wb_valid, 0);
    chk("freq_ready", i_ready, 1);

    // Flush while in WB drops the completion.
    i_valid = 1; i_info = {5'd2, 4'b0010, 32'h0, 32'h4002};
    tick();
    i_valid = 0;
    chk("fwb_valid", wb_valid, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("fwb_drop", wb_valid, 0);
    chk("fwb_ready", i_ready, 1);

    // Kill state must not leak into the next operation.
    run_op({5'd5, 4'b0010, 32'h0, 32'h1000}, 32'h0BADF00D, 0, 0);
    chk("post_kill_nwb", r_nwb, 1);
    chk("post_kill_data", r_data, 32'h0BADF00D);
    chk("post_kill_lat", r_wb_lat, 3);

    // Asynchronous reset mid-access.
    i_valid = 1; i_info = {5'd5, 4'b0010, 32'h0, 32'h1000};
    tick();
    i_valid = 0;
    chk("arst_pre", mem_if.mem_req_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_req_drop", mem_if.mem_req_valid, 0);
    chk("arst_ready", i_ready, 1);
    tick();
    rst_n = 1;
    tick();
    chk("arst_idle", i_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hicore_lsu.md
# hicore_lsu

Load/store unit that drains the memory-issue queue and performs one data-memory access at a time over a valid/ready request bus. It sits directly downstream of the memory-op queue and upstream of register writeback. It honours the per-entry cancel bit and the pipeline flush, and it generates byte strobes, load alignment and sign/zero extension. It also raises a misalignment error instead of issuing a bus access for misaligned operations.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- INFO_W, 73, width of `i_info`: {rd[4:0], op[3:0], wdata[31:0], addr[31:0]}, with addr in the LSBs.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  queue head valid.
- i_ready  out  1  entry accepted this cycle when high with i_valid.
- i_cancel  in  1  head entry is cancelled; consumed without access.
- i_info  in  INFO_W  packed operation.
- flush  in  1  kill all in-flight work.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  32  word-aligned address (addr[1:0]=0).
- mem_req_wen  out  1  store.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_req_wstrb  out  4  byte strobes (0 for loads).
- mem_rsp_valid  in  1  response; always accepted.
- mem_rsp_rdata  in  32  load word.
- wb_valid  out  1  completion valid.
- wb_ready  in  1  writeback accepts.
- wb_we  out  1  register write required (loads with rd≠0).
- wb_rd  out  5  destination.
- wb_data  out  32  extended load data.
- wb_err  out  1  misaligned access.
- wb_err_addr  out  32  faulting byte address.

## Operation
- op encoding: bit3 = store, bit2 = unsigned, bits1:0 = size (00 byte, 01 half, 10 word, 11 reserved→treated as word).
- FSM states:
  - IDLE: `i_ready` = 1. On acceptance:
    - cancel (i_cancel or flush same cycle) → stay IDLE, nothing else.
    - misaligned (half with addr[0]; word with addr[1:0]≠0) → WB with wb_err=1, wb_we=0.
    - otherwise → REQ.
  - REQ: `mem_req_valid` = 1. All request fields are stable until `mem_req_ready`; then → RESP.
  - RESP: wait `mem_rsp_valid`.
    - Load: capture extended data.
    - Store: ignore rdata.
    - Then → WB, or → IDLE if killed.
  - WB: `wb_valid` = 1 until `wb_ready` → IDLE.
- Store data and strobes:
  - Byte: data replicated ×4, strobe = 0001<<addr[1:0].
  - Half: data replicated ×2, strobe = 0011<<addr[1:0].
  - Word: data as-is, strobe = 1111.
- Load: select lane by addr[1:0], then sign- or zero-extend per bit2.
- Flush:
  - In REQ or RESP: set `killed`. The request is never withdrawn once asserted; it completes on the bus and its response is discarded with no wb.
  - In WB: → IDLE next cycle, wb_valid drops.
  - `killed` clears on return to IDLE.

## Timing
- Reset: state IDLE, killed 0. All outputs 0 except `i_ready`=1.
- Accept at cycle N → mem_req_valid from N+1.
- Request handshake at M → response earliest at M+1. Response at R → wb_valid at R+1.
- Minimum load latency, accept to wb_valid: 3 cycles with zero-wait memory. Misaligned: wb_valid at N+1.
- Throughput: one op in flight. `i_ready` is low in REQ/RESP/WB; it is a combinational function of state only.
- Flush and wb_ready in the same cycle: the completion counts as delivered; either way the next state is IDLE.
- mem_rsp_valid outside RESP is ignored.
- Reset asserted mid-access returns to IDLE asynchronously; the bus side must be reset together.

## Structure
- Shared package `hicore_lsu_pkg` holds:
  - op bit positions and size codes;
  - i_info field offsets;
  - the state enum (IDLE, REQ, RESP, WB).
- One sub-module, `hicore_lsu_align`, is combinational and handles:
  - store replication and strobes;
  - misalignment detect;
  - load lane select and extend.
- The FSM and registers are in the top level.

## Test plan
- Word load at 0x1000, rd=5, zero-wait bus returning 0xDEADBEEF → request addr 0x1000, wstrb 0; wb at +3 with rd 5, data 0xDEADBEEF, we=1.
- Signed byte load at 0x2003, rdata 0x80FF_FF7F → wb_data 0xFFFFFF80. The same access with unsigned op → 0x00000080.
- Half store at 0x3002, data 0x1234ABCD → addr 0x3000, wdata 0xABCDABCD, wstrb 1100. wb_valid follows with we=0.
- Word load at 0x4001 → no mem_req_valid; wb_err=1, wb_err_addr 0x4001 at N+1.
- i_cancel=1 entry → consumed in one cycle, no bus activity, no wb. Flush while in RESP → response consumed, no wb_valid, i_ready=1 the cycle after the response.
- mem_req_ready held low 5 cycles, then wb_ready held low 3 cycles → request fields stable throughout, wb fields stable, exactly one completion.
